// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and the baud-divisor helper used by the
//               receiver and the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Rounded to nearest so that tx and rx agree on the bit period.
    function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the rx pin plus falling-edge detect.
//               All flops reset to the idle line level (1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s    = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, LSB first, configurable data/stop bits, with a
//               single-entry valid/ready holding register and framing/overrun
//               pulses. Optional 2-of-3 sample voting: UART_RX_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  framing_error,
    output logic                  overrun
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = 1 + $clog2(CYCLES_PER_BIT);

    // The counter holds cycles elapsed since the last sample point; with voting
    // the decision lands one cycle after the nominal point, so restart at 2.
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int DECIDE_OFS = 1;
    localparam int RESTART    = 2;
`else
    localparam int DECIDE_OFS = 0;
    localparam int RESTART    = 1;
`endif

    localparam logic [CNT_W-1:0] C_HALF    = CNT_W'(HALF_BIT + DECIDE_OFS);
    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(CYCLES_PER_BIT + DECIDE_OFS);
    localparam logic [CNT_W-1:0] C_RESTART = CNT_W'(RESTART);
    localparam logic [3:0]       C_LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]       C_LAST_STOP = 4'(STOP_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx     (rx),
        .rx_s   (rx_s),
        .rx_fall(rx_fall)
    );

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  ferr_acc_q, ferr_acc_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  framing_error_q, framing_error_d;
    logic                  overrun_q, overrun_d;

    logic [CNT_W-1:0]      target;
    logic                  at_decide;
    logic                  sample_bit;
    logic [DATA_WIDTH-1:0] shift_in;
    logic                  commit;

    assign target    = (state_q == RX_START) ? C_HALF : C_FULL;
    assign at_decide = (cnt_q == target);

`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] vote_q, vote_d;

    assign sample_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

    always_comb begin
        vote_d = vote_q;
        if (cnt_q == target - CNT_W'(2)) vote_d[0] = rx_s;
        if (cnt_q == target - CNT_W'(1)) vote_d[1] = rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vote_q <= 2'b11;
        else        vote_q <= vote_d;
    end
`else
    assign sample_bit = rx_s;
`endif

    // New bits enter at the MSB so the first bit on the line ends up in bit 0.
    if (DATA_WIDTH > 1) begin : g_shift_wide
        assign shift_in = {sample_bit, shift_q[DATA_WIDTH-1:1]};
    end else begin : g_shift_one
        assign shift_in = sample_bit;
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        ferr_acc_d      = ferr_acc_q;
        data_out_d      = data_out_q;
        valid_d         = valid_q;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;
        commit          = 1'b0;

        if (valid_q && ready) valid_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (rx_fall) begin
                    state_d = RX_START;
                    cnt_d   = CNT_W'(1);
                end
            end
            RX_START: begin
                if (at_decide) begin
                    if (!sample_bit) begin
                        state_d   = RX_DATA;
                        cnt_d     = C_RESTART;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (at_decide) begin
                    shift_d = shift_in;
                    cnt_d   = C_RESTART;
                    if (bit_cnt_q == C_LAST_DATA) begin
                        state_d    = RX_STOP;
                        bit_cnt_d  = '0;
                        ferr_acc_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (at_decide) begin
                    cnt_d = C_RESTART;
                    if (bit_cnt_q == C_LAST_STOP) begin
                        // Leave mid-bit so the next start edge is not missed.
                        state_d   = RX_IDLE;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        if (ferr_acc_q || !sample_bit) framing_error_d = 1'b1;
                        else                           commit          = 1'b1;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        ferr_acc_d = ferr_acc_q | ~sample_bit;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A word consumed in the same cycle frees the slot for the new one.
        if (commit) begin
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end else begin
                data_out_d = shift_q;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RX_IDLE;
            cnt_q           <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            ferr_acc_q      <= 1'b0;
            data_out_q      <= '0;
            valid_q         <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            ferr_acc_q      <= ferr_acc_d;
            data_out_q      <= data_out_d;
            valid_q         <= valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    assign data_out      = data_out_q;
    assign valid         = valid_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW  = 8;
    localparam int CF  = 16;
    localparam int BR  = 1;
    localparam int SB  = 1;
    localparam int CPB = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx    = 1'b1;
    logic          ready = 1'b1;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          framing_error;
    logic          overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_WIDTH(DW),
        .BAUD_RATE (BR),
        .CLOCK_FREQ(CF),
        .STOP_BITS (SB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data_out     (data_out),
        .valid        (valid),
        .ready        (ready),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            fe_cnt   = 0;
    int            ov_cnt   = 0;
    logic [DW-1:0] words[$];

    // Monitor: accepted words and flag pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid && ready) words.push_back(data_out);
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (overrun)       ov_cnt <= ov_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // spike_bit >= 0 inverts that data bit for one cycle at its midpoint.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_val, input int spike_bit);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            if (i == spike_bit) begin
                rx = d[i];
                repeat (CPB/2) @(negedge clk);
                rx = ~d[i];
                @(negedge clk);
                rx = d[i];
                repeat (CPB/2 - 1) @(negedge clk);
            end else begin
                drive_bit(d[i]);
            end
        end
        for (int s = 0; s < SB; s++) drive_bit(stop_val);
        rx = 1'b1;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 ready = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int base;
    int fb;
    int ob;
    logic [DW-1:0] lb_exp[4];

    initial begin
        lb_exp[0] = 8'h00; lb_exp[1] = 8'hFF; lb_exp[2] = 8'h55; lb_exp[3] = 8'h80;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_data",  32'(data_out), 32'h0);
        check_val("rst_valid", 32'(valid), 32'h0);
        check_val("rst_ferr",  32'(framing_error), 32'h0);
        check_val("rst_ovr",   32'(overrun), 32'h0);
        rst_n = 1'b1;
        idle(20);

        // Single frame 0xA5 with ready high
        base = words.size(); fb = fe_cnt; ob = ov_cnt;
        send_frame(8'hA5, 1'b1, -1);
        idle(40);
        check_val("a5_count", 32'(words.size() - base), 32'd1);
        check_val("a5_data",  32'(words[base]), 32'hA5);
        check_val("a5_ferr",  32'(fe_cnt - fb), 32'd0);
        check_val("a5_ovr",   32'(ov_cnt - ob), 32'd0);
        check_val("a5_valid_cleared", 32'(valid), 32'h0);
        check_val("a5_data_held", 32'(data_out), 32'hA5);

        // Back-to-back frames
        base = words.size(); fb = fe_cnt; ob = ov_cnt;
        for (int k = 0; k < 4; k++) send_frame(lb_exp[k], 1'b1, -1);
        idle(40);
        check_val("lb_count", 32'(words.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) check_val($sformatf("lb_word%0d", k), 32'(words[base+k]), 32'(lb_exp[k]));
        check_val("lb_ferr", 32'(fe_cnt - fb), 32'd0);
        check_val("lb_ovr",  32'(ov_cnt - ob), 32'd0);

        // Stop bit low, then a good frame
        base = words.size(); fb = fe_cnt; ob = ov_cnt;
        send_frame(8'h3C, 1'b0, -1);
        idle(40);
        check_val("fe_pulses", 32'(fe_cnt - fb), 32'd1);
        check_val("fe_no_word", 32'(words.size() - base), 32'd0);
        check_val("fe_valid", 32'(valid), 32'h0);
        check_val("fe_ovr", 32'(ov_cnt - ob), 32'd0);
        send_frame(8'h12, 1'b1, -1);
        idle(40);
        check_val("fe_next_count", 32'(words.size() - base), 32'd1);
        check_val("fe_next_data", 32'(words[base]), 32'h12);
        check_val("fe_next_ferr", 32'(fe_cnt - fb), 32'd1);

        // Overrun with ready low
        set_ready(1'b0);
        base = words.size(); fb = fe_cnt; ob = ov_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle(40);
        check_val("ov_data", 32'(data_out), 32'h11);
        check_val("ov_valid", 32'(valid), 32'h1);
        check_val("ov_pulses", 32'(ov_cnt - ob), 32'd1);
        check_val("ov_ferr", 32'(fe_cnt - fb), 32'd0);
        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        check_val("ov_consumed_valid", 32'(valid), 32'h0);
        check_val("ov_consumed_data", 32'(data_out), 32'h11);
        check_val("ov_consumed_word", 32'(words[base]), 32'h11);

        // Short low pulse in idle
        base = words.size(); fb = fe_cnt; ob = ov_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check_val("gl_no_word", 32'(words.size() - base), 32'd0);
        check_val("gl_ferr", 32'(fe_cnt - fb), 32'd0);
        check_val("gl_ovr", 32'(ov_cnt - ob), 32'd0);
        check_val("gl_state", 32'(dut.state_q), 32'(RX_IDLE));
`ifdef UART_RX_GLITCH_FILTER_EN
        base = words.size();
        send_frame(8'hF0, 1'b1, 4);
        idle(40);
        check_val("gf_count", 32'(words.size() - base), 32'd1);
        check_val("gf_data", 32'(words[base]), 32'hF0);
`endif

        // Reset mid-frame
        set_ready(1'b0);
        @(negedge clk);
        send_frame(8'h77, 1'b1, -1);
        idle(40);
        check_val("mr_pre_valid", 32'(valid), 32'h1);
        check_val("mr_pre_data", 32'(data_out), 32'h77);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(((8'h99 >> i) & 8'h01) != 8'h00);
        repeat (5) @(negedge clk);
        check_val("mr_mid_state", 32'(dut.state_q), 32'(RX_DATA));
        #3 rst_n = 1'b0;
        #1;
        check_val("mr_data", 32'(data_out), 32'h0);
        check_val("mr_valid", 32'(valid), 32'h0);
        check_val("mr_ferr", 32'(framing_error), 32'h0);
        check_val("mr_ovr", 32'(overrun), 32'h0);
        check_val("mr_state", 32'(dut.state_q), 32'(RX_IDLE));
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        set_ready(1'b1);
        @(negedge clk);
        base = words.size(); fb = fe_cnt; ob = ov_cnt;
        send_frame(8'h42, 1'b1, -1);
        idle(40);
        check_val("mr_next_count", 32'(words.size() - base), 32'd1);
        check_val("mr_next_data", 32'(words[base]), 32'h42);
        check_val("mr_next_ferr", 32'(fe_cnt - fb), 32'd0);
        check_val("mr_next_ovr", 32'(ov_cnt - ob), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
